fifo_ptr_ctrl: RTL

Synchronous FIFO controller for the accelerator's on-chip line and feature-map buffers. It owns the write and read pointers of an external single-clock dual-port RAM and produces RAM addresses, occupancy count and full/empty/almost flags. It supports any DEPTH ≥ 2, including non-power-of-two. It adds a synchronous clear, programmable thresholds and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_wrap_ptr.sv | 57 +++++
 rtl/fifo_ptr_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO pointer controller: the pointer width function
// and the elaboration-time parameter legality check.
package fifo_pkg;

  // Address width for a RAM of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // DEPTH >= 2, AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1.
  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned af_thresh,
                                      input int unsigned ae_thresh);
    return (depth >= 2) && (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh + 1 <= depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping FIFO pointer: AW address bits plus one wrap bit. The address wraps
// at DEPTH-1 (non-power-of-two safe) and the wrap bit toggles on each wrap.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   inc        : advance the pointer this cycle
//   clr        : synchronous clear to 0 (priority over inc)
//   addr       : current address, always < DEPTH
//   wrap       : wrap bit
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] addr,
  output logic          wrap
);

  logic [AW-1:0] addr_q, addr_d;
  logic          wrap_q, wrap_d;

  // Next pointer value.
  always_comb begin
    addr_d = addr_q;
    wrap_d = wrap_q;
    if (clr) begin
      addr_d = '0;
      wrap_d = 1'b0;
    end else if (inc) begin
      if (addr_q == AW'(DEPTH - 1)) begin
        addr_d = '0;
        wrap_d = ~wrap_q;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Synchronous FIFO controller for a single-clock dual-port RAM. Owns the
// read/write pointers and produces RAM addresses, occupancy and status flags.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   clr                   : synchronous clear (empties FIFO, clears errors)
//   wr_req, rd_req        : producer / consumer requests
//   wr_en, rd_en          : accepted operations (combinational from state)
//   wr_addr, rd_addr      : RAM addresses
//   count                 : occupancy 0..DEPTH
//   full, empty           : registered status flags
//   almost_full/_empty    : registered threshold flags
//   overflow, underflow   : sticky error flags
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH     = 1024,
  parameter  int unsigned AF_THRESH = DEPTH - 4,
  parameter  int unsigned AE_THRESH = 4,
  localparam int unsigned AW        = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned CW = AW + 1;

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("fifo_ptr_ctrl: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_wrap, rd_wrap;

  // No bypass: a full FIFO only accepts the read, an empty one only the write.
  assign wr_en = wr_req & ~full_q  & ~clr;
  assign rd_en = rd_req & ~empty_q & ~clr;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .clr   (clr),
    .addr  (wr_addr),
    .wrap  (wr_wrap)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en),
    .clr   (clr),
    .addr  (rd_addr),
    .wrap  (rd_wrap)
  );

  // Next count, flags from the next count, sticky errors.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_en && !rd_en) begin
        count_d = count_q + CW'(1);
      end else if (rd_en && !wr_en) begin
        count_d = count_q - CW'(1);
      end
      ovf_d = ovf_q | (wr_req & full_q);
      unf_d = unf_q | (rd_req & empty_q);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_THRESH));
    ae_d    = (count_d <= CW'(AE_THRESH));
  end

  // Count, flag and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
